// File: rtl/score_pkg.sv
// score_pkg -- shared constants and helpers for the multi-player score tracker.
//
// Contents:
//   COMBO_W   : width of one lane's combo (multiplier) output
//   LEADER_W  : width of the leader index output (up to 8 players)
//   calc_mult : multiplier for a given streak, min(1 + streak/step, max_mult)
//   lane_lo   : LSB position of a lane inside a packed per-lane vector
package score_pkg;

  localparam int COMBO_W  = 3;
  localparam int LEADER_W = 3;

  function automatic logic [COMBO_W-1:0] calc_mult(input int streak,
                                                   input int combo_step,
                                                   input int max_mult);
    int m;
    m = 1 + streak / combo_step;
    if (m > max_mult) m = max_mult;
    return COMBO_W'(m);
  endfunction

  function automatic int lane_lo(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/score_lane.sv
// score_lane -- one player's scoring lane.
//
// Rising-edge detection on hit/miss, hit streak counter, combo multiplier and
// a saturating score register. The streak and multiplier logic exist only
// when SCORE_COMBO_EN is defined; otherwise every scoring hit adds 1 and the
// miss input is ignored.
//
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   clear_i      : synchronous round clear (score and streak to 0)
//   enable_i     : scoring gate
//   hit_i/miss_i : hit / miss levels, rising edge counts
//   score_o      : current score
//   combo_o      : current multiplier (0 without SCORE_COMBO_EN)
module score_lane
  import score_pkg::*;
#(
  parameter int SCORE_W    = 8,
  parameter int COMBO_STEP = 4,
  parameter int MAX_MULT   = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear_i,
  input  logic               enable_i,
  input  logic               hit_i,
  input  logic               miss_i,
  output logic [SCORE_W-1:0] score_o,
  output logic [COMBO_W-1:0] combo_o
);

  localparam int SUM_W = SCORE_W + COMBO_W;

  logic               hit_q;
  logic               hit_rise;
  logic [COMBO_W-1:0] mult;
  logic [SUM_W-1:0]   sum;
  logic [SCORE_W-1:0] score_q;
  logic [SCORE_W-1:0] score_d;

  // hit_q resets high so a hit already held through reset release is not
  // mistaken for a fresh edge on the first sampled clock.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values; combinational blocks use blocking (=).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) hit_q <= 1'b1;
    else          hit_q <= hit_i;
  end

  assign hit_rise = hit_i & ~hit_q;

`ifdef SCORE_COMBO_EN
  localparam int STREAK_MAX = COMBO_STEP * MAX_MULT;
  localparam int STREAK_W   = $clog2(STREAK_MAX + 1);

  logic                miss_q;
  logic                miss_rise;
  logic [STREAK_W-1:0] streak_q;
  logic [STREAK_W-1:0] streak_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) miss_q <= 1'b1;
    else          miss_q <= miss_i;
  end

  assign miss_rise = miss_i & ~miss_q;
  // Multiplier comes from the streak before this cycle's hit is counted.
  assign mult      = calc_mult(int'(streak_q), COMBO_STEP, MAX_MULT);
  assign combo_o   = mult;

  // A same-cycle miss wins over the hit's increment: the hit still scores
  // at the current multiplier, then the streak restarts.
  always_comb begin
    streak_d = streak_q;
    if (clear_i) begin
      streak_d = '0;
    end else if (enable_i) begin
      if (hit_rise && (streak_q != STREAK_W'(STREAK_MAX))) streak_d = streak_q + STREAK_W'(1);
      if (miss_rise) streak_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) streak_q <= '0;
    else          streak_q <= streak_d;
  end
`else
  logic unused_miss;
  localparam int unused_combo_cfg = COMBO_STEP + MAX_MULT;

  assign unused_miss = miss_i;
  assign mult        = COMBO_W'(1);
  assign combo_o     = '0;
`endif

  // Widened add: any carry into the upper bits means the score saturates.
  assign sum = SUM_W'(score_q) + SUM_W'(mult);

  // NOTE: every variable gets its default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    score_d = score_q;
    if (clear_i) begin
      score_d = '0;
    end else if (enable_i && hit_rise) begin
      score_d = (sum[SUM_W-1:SCORE_W] != '0) ? '1 : sum[SCORE_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) score_q <= '0;
    else          score_q <= score_d;
  end

  assign score_o = score_q;

endmodule

// File: rtl/score_tracker.sv
// score_tracker -- multi-player score tracker with streaks, combo
// multipliers, saturating scores, leader and session high score.
//
// Optional feature macro: SCORE_COMBO_EN (streaks and multipliers). Without
// it each scoring hit adds 1, miss is ignored and combo reads 0.
//
// Ports:
//   clk, reset_n  : clock, asynchronous active-low reset
//   clear         : synchronous round clear (scores/streaks, not high_score)
//   enable_score  : global scoring gate
//   hit, miss     : per-player levels, rising edge counts
//   score         : packed scores, player 0 in the LSBs
//   combo         : packed per-player multiplier
//   saturated     : per-player score pinned at all-ones
//   high_score    : session maximum of all scores
//   leader        : lowest index holding the maximum score
//   new_high      : one-cycle pulse when high_score increases
module score_tracker
  import score_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int SCORE_W     = 8,
  parameter int COMBO_STEP  = 4,
  parameter int MAX_MULT    = 4
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           clear,
  input  logic                           enable_score,
  input  logic [NUM_PLAYERS-1:0]         hit,
  input  logic [NUM_PLAYERS-1:0]         miss,
  output logic [NUM_PLAYERS*SCORE_W-1:0] score,
  output logic [NUM_PLAYERS*COMBO_W-1:0] combo,
  output logic [NUM_PLAYERS-1:0]         saturated,
  output logic [SCORE_W-1:0]             high_score,
  output logic [LEADER_W-1:0]            leader,
  output logic                           new_high
);

  logic [SCORE_W-1:0]  lane_score [NUM_PLAYERS];
  logic [SCORE_W-1:0]  max_score;
  logic [LEADER_W-1:0] max_idx;
  logic [SCORE_W-1:0]  high_score_q;
  logic [SCORE_W-1:0]  high_score_d;
  logic [LEADER_W-1:0] leader_q;
  logic                new_high_q;
  logic                new_high_d;

  for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_lane
    score_lane #(
      .SCORE_W   (SCORE_W),
      .COMBO_STEP(COMBO_STEP),
      .MAX_MULT  (MAX_MULT)
    ) u_lane (
      .clk     (clk),
      .reset_n (reset_n),
      .clear_i (clear),
      .enable_i(enable_score),
      .hit_i   (hit[i]),
      .miss_i  (miss[i]),
      .score_o (score[lane_lo(i, SCORE_W) +: SCORE_W]),
      .combo_o (combo[lane_lo(i, COMBO_W) +: COMBO_W])
    );

    assign lane_score[i] = score[lane_lo(i, SCORE_W) +: SCORE_W];
    assign saturated[i]  = &lane_score[i];
  end

  // Strict '>' keeps the lowest index on ties.
  always_comb begin
    max_score = lane_score[0];
    max_idx   = '0;
    for (int i = 1; i < NUM_PLAYERS; i++) begin
      if (lane_score[i] > max_score) begin
        max_score = lane_score[i];
        max_idx   = LEADER_W'(i);
      end
    end
  end

  always_comb begin
    new_high_d   = (max_score > high_score_q);
    high_score_d = new_high_d ? max_score : high_score_q;
  end

  // Tracking registers are untouched by clear: the session high survives.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      high_score_q <= '0;
      leader_q     <= '0;
      new_high_q   <= 1'b0;
    end else begin
      high_score_q <= high_score_d;
      leader_q     <= max_idx;
      new_high_q   <= new_high_d;
    end
  end

  assign high_score = high_score_q;
  assign leader     = leader_q;
  assign new_high   = new_high_q;

endmodule
